pixel_fetch_sched: RTL
======================

PIXEL_FETCH_SCHED -- requirements
Module: pixel_fetch_sched

Interface
REQ-001 SHALL have parameters: H_TOTAL 800, line length in pixels; V_TOTAL 525, frame length in lines; H_VIS 640, visible pixels per line; V_VIS 480, visible lines.
REQ-002 SHALL have parameters: H_SYNC_S 656 and H_SYNC_E 751, hsync low window inclusive; V_SYNC_S 490 and V_SYNC_E 491, vsync low window inclusive.
REQ-003 SHALL have one clock and a synchronous active-high reset; ports are listed below, clock and reset first.
REQ-004 pixel_clk  in  1  sole clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 hs, vs  out  1 each  active-low syncs, aligned to color_mapper output.
REQ-007 blank  out  1  1 = visible pixel, 0 = blanking; drives color_mapper blank.
REQ-008 DrawX, DrawY  out  10 each  current counter position (stage 0).
REQ-009 frame_start  out  1  one-cycle pulse when counters are at (0,0).
REQ-010 IDX_Red, IDX_Green, IDX_Blue  out  4 each  fetched colour to color_mapper.
REQ-011 mem_addr  out  12  shared cell-RAM address; mem_we out 1; mem_wdata out 12.
REQ-012 mem_rdata  in  12  RAM data, {R,G,B}, valid one cycle after address.
REQ-013 cpu_req, cpu_we  in  1 each  CPU access request and write enable.
REQ-014 cpu_addr  in  12  CPU address; cpu_wdata in 12 CPU write data.
REQ-015 cpu_gnt  out  1  request accepted this cycle.
REQ-016 cpu_rdata  out  12  read data; cpu_rvalid out 1 marks it valid.

Function
REQ-017 hcount SHALL increment every cycle and wrap H_TOTAL-1 -> 0; on that wrap vcount SHALL increment, wrapping V_TOTAL-1 -> 0.
REQ-018 Stage-0 visibility is vis0 = (hcount < H_VIS) && (vcount < V_VIS).
REQ-019 When vis0, mem_addr SHALL be {vcount[9:4], hcount[9:4]} with mem_we 0; video has absolute priority.
REQ-020 When !vis0 and cpu_req, cpu_gnt SHALL be 1 the same cycle and mem_addr/mem_we/mem_wdata SHALL equal cpu_addr/cpu_we/cpu_wdata.
REQ-021 cpu_gnt SHALL be 0 whenever vis0 or !cpu_req; the CPU holds its request until granted; at most one access per cycle.
REQ-022 When !vis0 and !cpu_req, mem_we SHALL be 0 and mem_addr 0.
REQ-023 cpu_rvalid SHALL pulse one cycle after a granted read (cpu_we 0), with cpu_rdata = mem_rdata; writes produce no rvalid.
REQ-024 IDX_* SHALL register mem_rdata[11:8], [7:4] and [3:0] one cycle after a video fetch; during non-video cycles IDX_* SHALL be 0.
REQ-025 blank SHALL be vis0 delayed one cycle, aligned with IDX_*.
REQ-026 hs and vs SHALL be the raw syncs delayed two cycles, matching color_mapper's extra register.
REQ-027 Raw hs SHALL be 0 iff H_SYNC_S <= hcount <= H_SYNC_E; raw vs SHALL be 0 iff V_SYNC_S <= vcount <= V_SYNC_E.
REQ-028 A pending cpu_req at the transition into visible SHALL be denied from the first visible cycle with no partial access.
REQ-029 A cpu_req asserted in the last blank cycle (h=799, v=524) SHALL be granted in that cycle.

Reset
REQ-030 On reset: hcount = vcount = 0; hs = vs = 1; blank = 0; IDX_* = 0; cpu_gnt = cpu_rvalid = 0; mem_we = 0; pipeline delay registers cleared to their idle values.
REQ-031 Reset asserted mid-frame SHALL restart at (0,0) on the cycle after release and discard any in-flight cpu_rvalid.

Structure
REQ-032 Timing parameters and the 12-bit RGB cell type SHALL live in a shared package vga_pkg.
REQ-033 Counters and sync generation SHALL be one sub-module, vga_timing_gen; arbitration and the pixel pipeline stay in the top level.

Verification
REQ-034 Reset, then run 420000 cycles -> exactly one frame_start every 420000 cycles; hs low 96 cycles per line; vs low 2 lines per frame.
REQ-035 RAM cell 0x000 = 0xF0A, counters at (0,0) -> one cycle later IDX = F,0,A and blank = 1; hs matches the raw-sync value two cycles later.
REQ-036 cpu_req held from h=630 (write, addr 0x123, data 0xABC) -> gnt at h=640 only; cell 0x123 = 0xABC afterwards.
REQ-037 CPU read of 0x123 during vblank -> gnt same cycle, rvalid next cycle with rdata 0xABC.
REQ-038 cpu_req asserted at (799,524) -> granted; next cycle (0,0) is a video fetch with gnt = 0.
REQ-039 Reset pulsed at (300,200) with a read in flight -> no rvalid; restart at (0,0); all outputs at reset values.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, bus widths and the cell-RAM colour type.
package vga_pkg;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned H_VIS    = 640;
  localparam int unsigned V_VIS    = 480;
  localparam int unsigned H_SYNC_S = 656;
  localparam int unsigned H_SYNC_E = 751;
  localparam int unsigned V_SYNC_S = 490;
  localparam int unsigned V_SYNC_E = 491;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CELL_W = 12;
  localparam int unsigned CH_W   = 4;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_cell_t;

  // One RAM cell covers a 16x16 pixel tile.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [CNT_W-1:0] h,
                                                  input logic [CNT_W-1:0] v);
    return {v[9:4], h[9:4]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters with raw (undelayed) sync and visibility decode.
module vga_timing_gen #(
  parameter int unsigned H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int unsigned H_VIS    = vga_pkg::H_VIS,
  parameter int unsigned V_VIS    = vga_pkg::V_VIS,
  parameter int unsigned H_SYNC_S = vga_pkg::H_SYNC_S,
  parameter int unsigned H_SYNC_E = vga_pkg::H_SYNC_E,
  parameter int unsigned V_SYNC_S = vga_pkg::V_SYNC_S,
  parameter int unsigned V_SYNC_E = vga_pkg::V_SYNC_E
) (
  input  logic                       pixel_clk,
  input  logic                       reset,
  output logic [vga_pkg::CNT_W-1:0]  hcount,
  output logic [vga_pkg::CNT_W-1:0]  vcount,
  output logic                       hs_raw_c,
  output logic                       vs_raw_c,
  output logic                       vis_c
);

  localparam int unsigned CW = vga_pkg::CNT_W;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == CW'(H_TOTAL - 1)) begin
      hcount <= '0;
      vcount <= (vcount == CW'(V_TOTAL - 1)) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  always_comb begin
    hs_raw_c = !((hcount >= CW'(H_SYNC_S)) && (hcount <= CW'(H_SYNC_E)));
    vs_raw_c = !((vcount >= CW'(V_SYNC_S)) && (vcount <= CW'(V_SYNC_E)));
    vis_c    = (hcount < CW'(H_VIS)) && (vcount < CW'(V_VIS));
  end

endmodule

// File: rtl/pixel_fetch_sched.sv
// Cell-RAM arbiter: video fetch has absolute priority, CPU uses blanking slots;
// fetched colour, blank and syncs are pipelined to line up at color_mapper.
module pixel_fetch_sched #(
  parameter int unsigned H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int unsigned H_VIS    = vga_pkg::H_VIS,
  parameter int unsigned V_VIS    = vga_pkg::V_VIS,
  parameter int unsigned H_SYNC_S = vga_pkg::H_SYNC_S,
  parameter int unsigned H_SYNC_E = vga_pkg::H_SYNC_E,
  parameter int unsigned V_SYNC_S = vga_pkg::V_SYNC_S,
  parameter int unsigned V_SYNC_E = vga_pkg::V_SYNC_E
) (
  input  logic                        pixel_clk,
  input  logic                        reset,
  output logic                        hs,
  output logic                        vs,
  output logic                        blank,
  output logic [vga_pkg::CNT_W-1:0]   DrawX,
  output logic [vga_pkg::CNT_W-1:0]   DrawY,
  output logic                        frame_start,
  output logic [vga_pkg::CH_W-1:0]    IDX_Red,
  output logic [vga_pkg::CH_W-1:0]    IDX_Green,
  output logic [vga_pkg::CH_W-1:0]    IDX_Blue,
  output logic [vga_pkg::ADDR_W-1:0]  mem_addr,
  output logic                        mem_we,
  output logic [vga_pkg::CELL_W-1:0]  mem_wdata,
  input  logic [vga_pkg::CELL_W-1:0]  mem_rdata,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [vga_pkg::ADDR_W-1:0]  cpu_addr,
  input  logic [vga_pkg::CELL_W-1:0]  cpu_wdata,
  output logic                        cpu_gnt,
  output logic [vga_pkg::CELL_W-1:0]  cpu_rdata,
  output logic                        cpu_rvalid
);

  import vga_pkg::rgb_cell_t;
  import vga_pkg::cell_addr;

  logic [vga_pkg::CNT_W-1:0] hcount;
  logic [vga_pkg::CNT_W-1:0] vcount;
  logic                      hs_raw;
  logic                      vs_raw;
  logic                      vis0;
  logic                      vid_q;
  logic                      rd_q;
  logic [1:0]                hs_q;
  logic [1:0]                vs_q;
  rgb_cell_t                 pixel;

  vga_timing_gen #(
    .H_TOTAL (H_TOTAL),  .V_TOTAL (V_TOTAL),
    .H_VIS   (H_VIS),    .V_VIS   (V_VIS),
    .H_SYNC_S(H_SYNC_S), .H_SYNC_E(H_SYNC_E),
    .V_SYNC_S(V_SYNC_S), .V_SYNC_E(V_SYNC_E)
  ) u_timing (
    .pixel_clk(pixel_clk),
    .reset    (reset),
    .hcount   (hcount),
    .vcount   (vcount),
    .hs_raw_c (hs_raw),
    .vs_raw_c (vs_raw),
    .vis_c    (vis0)
  );

  assign DrawX       = hcount;
  assign DrawY       = vcount;
  assign frame_start = (hcount == '0) && (vcount == '0);

  // Single-port arbitration; a CPU request is only honoured in a blanking cycle.
  always_comb begin
    cpu_gnt   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (vis0) begin
      mem_addr = cell_addr(hcount, vcount);
    end else if (cpu_req && !reset) begin
      cpu_gnt   = 1'b1;
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      vid_q <= 1'b0;
      rd_q  <= 1'b0;
      hs_q  <= 2'b11;
      vs_q  <= 2'b11;
    end else begin
      vid_q <= vis0;
      rd_q  <= cpu_gnt && !cpu_we;
      hs_q  <= {hs_q[0], hs_raw};
      vs_q  <= {vs_q[0], vs_raw};
    end
  end

  // RAM output is already the fetch register; gate it by the delayed fetch flag.
  assign pixel      = rgb_cell_t'(mem_rdata);
  assign IDX_Red    = vid_q ? pixel.r : '0;
  assign IDX_Green  = vid_q ? pixel.g : '0;
  assign IDX_Blue   = vid_q ? pixel.b : '0;
  assign blank      = vid_q;
  assign hs         = hs_q[1];
  assign vs         = vs_q[1];
  assign cpu_rvalid = rd_q && !reset;
  assign cpu_rdata  = rd_q ? mem_rdata : '0;

endmodule
